ctrl_sel_stream_mux: RTL and testbench

Packet-granular stream multiplexer that consumes one replica of the selector index produced by the control selector and forwards exactly one complete AXI-stream packet from the selected input port to a single output. It sits directly downstream of the selector: each accepted selector token moves one whole packet, head to `tlast` inclusive, then retires. This keeps each packet contiguous and keeps the selector's per-port inflight counts consistent with the data path.

---
 rtl/ctrl_sel_pkg.sv | 19 +
 rtl/axis_out_reg.sv | 56 +++++
 rtl/ctrl_sel_stream_mux.sv | 115 +++++++++++
 tb/tb_ctrl_sel_stream_mux.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_sel_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ctrl_sel_pkg : FSM state type and packed-slice helper for ctrl_sel_stream_mux
// Rev 1.0
// ----------------------------------------------------------------------------
package ctrl_sel_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FWD  = 1'b1
  } state_t;

  // Low bit of slice idx in a vector of equal-width packed slices.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_out_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_out_reg : single-entry AXI-stream output register with valid/ready
// Rev 1.0
// ----------------------------------------------------------------------------
module axis_out_reg #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [KEEP_WIDTH-1:0] i_keep,
  input  logic                  i_last,
  output logic                  o_load,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic [KEEP_WIDTH-1:0] o_tkeep,
  output logic                  o_tlast,
  output logic                  o_tvalid,
  input  logic                  i_tready
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [KEEP_WIDTH-1:0] r_keep;
  logic                  r_last;

  // Register can take a beat when empty or when its current beat leaves this cycle.
  assign o_load = !r_valid || i_tready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else begin
      if (i_wr) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
        r_keep  <= i_keep;
        r_last  <= i_last;
      end else if (i_tready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_tdata  = r_data;
  assign o_tkeep  = r_keep;
  assign o_tlast  = r_last;
  assign o_tvalid = r_valid;

endmodule
`default_nettype wire

// File: rtl/ctrl_sel_stream_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ctrl_sel_stream_mux : forwards one whole packet per selector token
// Rev 1.0
// ----------------------------------------------------------------------------
module ctrl_sel_stream_mux
  import ctrl_sel_pkg::*;
#(
  parameter int S_COUNT      = 2,
  parameter int SELECT_WIDTH = (S_COUNT > 1) ? $clog2(S_COUNT) : 1,
  parameter int DATA_WIDTH   = 512,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SELECT_WIDTH-1:0]       s_selector_tdata,
  input  logic                          s_selector_tvalid,
  output logic                          s_selector_tready,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_in_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_in_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_in_tlast,
  input  logic [S_COUNT-1:0]            s_axis_in_tvalid,
  output logic [S_COUNT-1:0]            s_axis_in_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_out_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_out_tkeep,
  output logic                          m_axis_out_tlast,
  output logic                          m_axis_out_tvalid,
  input  logic                          m_axis_out_tready,
  output logic                          sel_err,
  output logic [31:0]                   pkt_count
);

  localparam logic [SELECT_WIDTH:0] c_S_COUNT = S_COUNT[SELECT_WIDTH:0];

  state_t                  r_state;
  logic [SELECT_WIDTH-1:0] r_cur;
  logic                    r_sel_err;
  logic [31:0]             r_pkt_count;

  logic [DATA_WIDTH-1:0]   w_data_arr [S_COUNT];
  logic [KEEP_WIDTH-1:0]   w_keep_arr [S_COUNT];
  logic                    w_load;
  logic                    w_fwd;
  logic                    w_beat;
  logic                    w_pkt_end;
  logic                    w_tok;
  logic                    w_in_range;

  for (genvar g = 0; g < S_COUNT; g++) begin : g_slice
    localparam int c_DLO = slice_lo(g, DATA_WIDTH);
    localparam int c_KLO = slice_lo(g, KEEP_WIDTH);
    assign w_data_arr[g] = s_axis_in_tdata[c_DLO +: DATA_WIDTH];
    assign w_keep_arr[g] = s_axis_in_tkeep[c_KLO +: KEEP_WIDTH];
  end

  assign w_fwd     = (r_state == FWD);
  assign w_beat    = w_fwd && w_load && s_axis_in_tvalid[r_cur];
  assign w_pkt_end = w_beat && s_axis_in_tlast[r_cur];

  // Opening the selector in the tlast cycle lets the next packet start without a bubble.
  assign s_selector_tready = !w_fwd || w_pkt_end;
  assign w_tok             = s_selector_tvalid && s_selector_tready;
  assign w_in_range        = ({1'b0, s_selector_tdata} < c_S_COUNT);

  always_comb begin
    s_axis_in_tready = '0;
    if (w_fwd) begin
      s_axis_in_tready[r_cur] = w_load;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cur       <= '0;
      r_sel_err   <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_sel_err <= w_tok && !w_in_range;
      if (m_axis_out_tvalid && m_axis_out_tready && m_axis_out_tlast) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
      // A token is only accepted in IDLE or at packet end, so one branch covers both.
      if (w_tok && w_in_range) begin
        r_state <= FWD;
        r_cur   <= s_selector_tdata;
      end else if (w_pkt_end) begin
        r_state <= IDLE;
      end
    end
  end

  axis_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .i_wr     (w_beat),
    .i_data   (w_data_arr[r_cur]),
    .i_keep   (w_keep_arr[r_cur]),
    .i_last   (s_axis_in_tlast[r_cur]),
    .o_load   (w_load),
    .o_tdata  (m_axis_out_tdata),
    .o_tkeep  (m_axis_out_tkeep),
    .o_tlast  (m_axis_out_tlast),
    .o_tvalid (m_axis_out_tvalid),
    .i_tready (m_axis_out_tready)
  );

  assign sel_err   = r_sel_err;
  assign pkt_count = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sel_stream_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ctrl_sel_stream_mux : directed bench with packet-level scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ctrl_sel_stream_mux;

  localparam int c_N  = 3;
  localparam int c_DW = 32;
  localparam int c_KW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        sel_tdata;
  logic              sel_tvalid;
  logic              sel_tready;
  logic [c_N*c_DW-1:0] in_tdata;
  logic [c_N*c_KW-1:0] in_tkeep;
  logic [c_N-1:0]    in_tlast;
  logic [c_N-1:0]    in_tvalid;
  logic [c_N-1:0]    in_tready;
  logic [c_DW-1:0]   m_tdata;
  logic [c_KW-1:0]   m_tkeep;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic              sel_err;
  logic [31:0]       pkt_count;

  ctrl_sel_stream_mux #(
    .S_COUNT    (c_N),
    .DATA_WIDTH (c_DW),
    .KEEP_WIDTH (c_KW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_selector_tdata  (sel_tdata),
    .s_selector_tvalid (sel_tvalid),
    .s_selector_tready (sel_tready),
    .s_axis_in_tdata   (in_tdata),
    .s_axis_in_tkeep   (in_tkeep),
    .s_axis_in_tlast   (in_tlast),
    .s_axis_in_tvalid  (in_tvalid),
    .s_axis_in_tready  (in_tready),
    .m_axis_out_tdata  (m_tdata),
    .m_axis_out_tkeep  (m_tkeep),
    .m_axis_out_tlast  (m_tlast),
    .m_axis_out_tvalid (m_tvalid),
    .m_axis_out_tready (m_tready),
    .sel_err           (sel_err),
    .pkt_count         (pkt_count)
  );

  always #5 clk = ~clk;

  // Beat record: {data, keep, last}
  logic [36:0] pmem [c_N][64];
  int          pwr [c_N];
  int          prd [c_N];
  logic [1:0]  tmem [64];
  int          twr, trd;
  logic [36:0] exp_q [$];
  logic [36:0] got_q [$];
  logic [31:0] model_cnt;

  int          errors, checks;
  int          cyc, tok_cyc, first_cyc, last_cyc;
  int          out_cnt, in_hs_cnt, sel_err_cnt;
  logic [2:0]  tready_seen;
  logic [2:0]  hs;
  logic        tok_hs;
  logic        stall_prev;
  logic [36:0] held, e, cur_beat;
  logic [31:0] cnt0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input int port, input int n, input logic [31:0] base);
    logic [36:0] b;
    tmem[twr] = port[1:0];
    twr++;
    for (int i = 0; i < n; i++) begin
      b = {base + 32'(i), (i == n - 1) ? 4'h3 : 4'hF, (i == n - 1)};
      pmem[port][pwr[port]] = b;
      pwr[port]++;
      exp_q.push_back(b);
    end
  endtask

  task automatic send_tok(input logic [1:0] idx);
    tmem[twr] = idx;
    twr++;
  endtask

  task automatic clear_stats();
    out_cnt = 0; in_hs_cnt = 0; sel_err_cnt = 0;
    first_cyc = -1; last_cyc = -1; tok_cyc = -1;
    tready_seen = '0;
    got_q.delete();
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && trd == twr && !m_tvalid) break;
    end
    if (i == budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got pending=%0d expected 0", name, exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor (negedge) and upstream driver (posedge + 1)
  always begin
    @(negedge clk);
    cyc++;
    hs     = in_tvalid & in_tready;
    tok_hs = sel_tvalid && sel_tready;
    if (rst) begin
      chk("pkt_count", pkt_count, model_cnt);
      chk("tready_onehot", 64'($countones(in_tready) <= 1), 1);
      cur_beat = {m_tdata, m_tkeep, m_tlast};
      if (stall_prev) chk("stall_hold", {m_tvalid, cur_beat}, {1'b1, held});
      stall_prev = m_tvalid && !m_tready;
      held       = cur_beat;
      if (m_tvalid && m_tready) begin
        got_q.push_back(cur_beat);
        out_cnt++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {1'b1, cur_beat}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", cur_beat, e);
          if (e[0]) model_cnt++;
        end
      end
      tready_seen |= in_tready;
      if (sel_err) sel_err_cnt++;
      if (tok_hs) tok_cyc = cyc;
    end else begin
      stall_prev = 1'b0;
    end
    @(posedge clk); #1;
    for (int p = 0; p < c_N; p++) begin
      if (hs[p]) begin
        prd[p]++;
        in_hs_cnt++;
      end
    end
    if (tok_hs) trd++;
    for (int p = 0; p < c_N; p++) begin
      if (prd[p] < pwr[p]) begin
        in_tvalid[p]           = 1'b1;
        in_tdata[p*c_DW +: c_DW] = pmem[p][prd[p]][36:5];
        in_tkeep[p*c_KW +: c_KW] = pmem[p][prd[p]][4:1];
        in_tlast[p]            = pmem[p][prd[p]][0];
      end else begin
        in_tvalid[p] = 1'b0;
      end
    end
    sel_tvalid = (trd < twr);
    if (sel_tvalid) sel_tdata = tmem[trd];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0; cyc = 0; model_cnt = '0;
    twr = 0; trd = 0; stall_prev = 1'b0; held = '0;
    for (int p = 0; p < c_N; p++) begin pwr[p] = 0; prd[p] = 0; end
    sel_tdata = '0; sel_tvalid = 1'b0;
    in_tdata = '0; in_tkeep = '0; in_tlast = '0; in_tvalid = '0;
    m_tready = 1'b1;
    clear_stats();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_beat", {m_tdata, m_tkeep, m_tlast}, 0);
    chk("rst_in_tready", in_tready, 0);
    chk("rst_sel_tready", sel_tready, 1);
    chk("rst_sel_err", sel_err, 0);
    chk("rst_pkt_count", pkt_count, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic forwarding from port 1
    clear_stats();
    send(1, 3, 32'hA1);
    wait_done("basic", 50);
    chk("basic_beats", out_cnt, 3);
    chk("basic_b0", (got_q.size() > 0) ? got_q[0] : '0, {32'hA1, 4'hF, 1'b0});
    chk("basic_b2", (got_q.size() > 2) ? got_q[2] : '0, {32'hA3, 4'h3, 1'b1});
    chk("basic_p0_tready", tready_seen[0], 0);
    chk("basic_pkt_count", pkt_count, 1);
    chk("basic_latency", 64'(first_cyc - tok_cyc), 2);

    // Back-to-back tokens 0,1,0
    clear_stats();
    cnt0 = pkt_count;
    send(0, 2, 32'h200);
    send(1, 2, 32'h300);
    send(0, 2, 32'h400);
    wait_done("b2b", 60);
    chk("b2b_beats", out_cnt, 6);
    chk("b2b_span", 64'(last_cyc - first_cyc), 5);
    chk("b2b_pkts", pkt_count - cnt0, 3);
    chk("b2b_p2_tready", tready_seen[2], 0);

    // Backpressure 1,0,0,1 on a 4-beat packet
    clear_stats();
    cnt0 = pkt_count;
    send(0, 4, 32'h100);
    for (int i = 0; i < 20 && !m_tvalid; i++) begin
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    @(posedge clk); #1; m_tready = 1'b0;
    @(posedge clk); #1; m_tready = 1'b0;
    @(posedge clk); #1; m_tready = 1'b1;
    wait_done("bp", 50);
    chk("bp_beats", out_cnt, 4);
    chk("bp_in_hs", in_hs_cnt, 4);
    chk("bp_pkts", pkt_count - cnt0, 1);

    // Out-of-range selector index
    clear_stats();
    cnt0 = pkt_count;
    send_tok(2'd3);
    repeat (6) @(posedge clk);
    #1;
    chk("oor_sel_err_pulses", sel_err_cnt, 1);
    chk("oor_any_tready", tready_seen, 0);
    chk("oor_sel_tready", sel_tready, 1);
    chk("oor_tok_taken", 64'(twr - trd), 0);
    chk("oor_pkts", pkt_count, cnt0);

    // Reset in the middle of a 4-beat packet
    clear_stats();
    send(0, 4, 32'h500);
    for (int i = 0; i < 30 && out_cnt < 2; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_tvalid", m_tvalid, 0);
    chk("mid_rst_beat", {m_tdata, m_tkeep, m_tlast}, 0);
    chk("mid_rst_in_tready", in_tready, 0);
    chk("mid_rst_sel_tready", sel_tready, 1);
    chk("mid_rst_sel_err", sel_err, 0);
    chk("mid_rst_pkt_count", pkt_count, 0);
    for (int p = 0; p < c_N; p++) prd[p] = pwr[p];
    trd = twr;
    exp_q.delete();
    model_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    clear_stats();
    send(0, 1, 32'h600);
    wait_done("post_rst", 50);
    chk("post_rst_beats", out_cnt, 1);
    chk("post_rst_b0", (got_q.size() > 0) ? got_q[0] : '0, {32'h600, 4'h3, 1'b1});
    chk("post_rst_pkt_count", pkt_count, 1);

    // Counter wrap
    model_cnt = 32'hFFFF_FFFF;
    force dut.r_pkt_count = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.r_pkt_count;
    chk("wrap_preload", pkt_count, 32'hFFFF_FFFF);
    send(1, 1, 32'h700);
    wait_done("wrap", 50);
    chk("wrap_pkt_count", pkt_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
